uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (serializer/FSM/parity/mux) between NUM_REQ byte requesters.
- Round-robin grant; presents one byte at a time on the transmitter's p_data/data_valid/par_en/par_type inputs.
- Sequences each frame by tracking the transmitter's busy output.
- Enforces a programmable idle gap between frames; reports which requester owns the current frame.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter front-end arbiter:
// FSM state encoding and the default byte width.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int STATE_W         = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first asserted request
// at or after ptr, wrapping cyclically.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any_req
);

  localparam int IW = $clog2(N);

  // Scan from the furthest offset down so the nearest request to ptr wins.
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    j       = 0;
    jj      = '0;
    gnt     = '0;
    idx     = '0;
    any_req = |req;
    for (int k = N - 1; k >= 0; k--) begin
      j  = (int'(ptr) + k) % N;
      jj = IW'(j);
      if (req[jj]) begin
        gnt     = '0;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end that shares one UART transmitter between NUM_REQ byte
// sources, sequencing each frame off the transmitter's busy flag.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int NUM_REQ      = 4,
  parameter int GAP_WIDTH    = 4,
  parameter int BUSY_TIMEOUT = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          cfg_par_en,
  input  logic                          cfg_par_type,
  input  logic [GAP_WIDTH-1:0]          cfg_gap,
  input  logic                          tx_busy,
  output logic [DATA_WIDTH-1:0]         tx_p_data,
  output logic                          tx_data_valid,
  output logic                          tx_par_en,
  output logic                          tx_par_type,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          frame_done,
  output logic                          timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         gid_q, gid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pen_q, pen_d;
  logic                  ptype_q, ptype_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [GAP_WIDTH-1:0]  gcnt_q, gcnt_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gid_d         = gid_q;
    data_d        = data_q;
    pen_d         = pen_q;
    ptype_d       = ptype_q;
    tcnt_d        = tcnt_q;
    gcnt_d        = gcnt_q;
    req_ready     = '0;
    tx_data_valid = 1'b0;
    frame_done    = 1'b0;
    timeout_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_any && !tx_busy) begin
          req_ready = arb_gnt;
          data_d    = sel_data;
          pen_d     = cfg_par_en;
          ptype_d   = cfg_par_type;
          gid_d     = arb_idx;
          ptr_d     = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
          state_d   = LOAD;
        end
      end
      LOAD: begin
        tx_data_valid = 1'b1;
        tcnt_d        = '0;
        state_d       = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tcnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          // The transmitter never acknowledged the load; give up on this byte.
          timeout_err = 1'b1;
          gcnt_d      = cfg_gap;
          state_d     = GAP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          frame_done = 1'b1;
          gcnt_d     = cfg_gap;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (gcnt_q > GAP_WIDTH'(1)) gcnt_d = gcnt_q - GAP_WIDTH'(1);
        else                        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes must not leak out while reset is being applied.
    if (!rst) begin
      req_ready     = '0;
      tx_data_valid = 1'b0;
      frame_done    = 1'b0;
      timeout_err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      ptype_q <= 1'b0;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      ptype_q <= ptype_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign tx_p_data   = data_q;
  assign tx_par_en   = pen_q;
  assign tx_par_type = ptype_q;
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple busy model of the UART
// transmitter (busy high for busy_len cycles after each load strobe).
module tb_uart_tx_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int GW = 4;
  localparam int BT = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             cfg_par_en;
  logic             cfg_par_type;
  logic [GW-1:0]    cfg_gap;
  logic             tx_busy;
  logic [DW-1:0]    tx_p_data;
  logic             tx_data_valid;
  logic             tx_par_en;
  logic             tx_par_type;
  logic [1:0]       grant_id;
  logic             frame_done;
  logic             timeout_err;

  logic model_en;
  logic forced_busy;
  int   busy_len;
  int   mcnt;

  int tests = 0;
  int fails = 0;

  uart_tx_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .GAP_WIDTH(GW), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .cfg_par_en(cfg_par_en), .cfg_par_type(cfg_par_type),
    .cfg_gap(cfg_gap), .tx_busy(tx_busy), .tx_p_data(tx_p_data),
    .tx_data_valid(tx_data_valid), .tx_par_en(tx_par_en), .tx_par_type(tx_par_type),
    .grant_id(grant_id), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!model_en)          mcnt <= 0;
    else if (tx_data_valid) mcnt <= busy_len;
    else if (mcnt > 0)      mcnt <= mcnt - 1;
  end

  assign tx_busy = model_en ? (mcnt > 0) : forced_busy;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; model_en = 1'b0; forced_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0; model_en = 1'b0; forced_busy = 1'b0;
    req_valid = 4'b1111; req_data = 32'h44332211;
    cfg_par_en = 1'b1; cfg_par_type = 1'b1; cfg_gap = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    tests++; if (tx_data_valid !== 1'b0) begin fails++; $display("FAIL reset_data_valid: got %b expected 0", tx_data_valid); end
    tests++; if (tx_p_data !== 8'h00) begin fails++; $display("FAIL reset_p_data: got %h expected 00", tx_p_data); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    tests++; if ({tx_par_en, tx_par_type, frame_done, timeout_err} !== 4'b0000) begin
      fails++; $display("FAIL reset_misc: got %b expected 0000", {tx_par_en, tx_par_type, frame_done, timeout_err}); end
    do_reset();
  endtask

  task automatic test_single();
    int nfd, fd_at;
    do_reset();
    req_data = 32'h00A5_0000; cfg_par_en = 1'b1; cfg_par_type = 1'b0; cfg_gap = '0;
    busy_len = 11; model_en = 1'b1; req_valid = 4'b0100;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    tests++; if (tx_data_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", tx_data_valid); end
    tests++; if (tx_p_data !== 8'hA5) begin fails++; $display("FAIL single_data: got %h expected a5", tx_p_data); end
    tests++; if ({tx_par_en, tx_par_type} !== 2'b10) begin fails++; $display("FAIL single_parity: got %b expected 10", {tx_par_en, tx_par_type}); end
    tests++; if (grant_id !== 2'd2) begin fails++; $display("FAIL single_grant_id: got %0d expected 2", grant_id); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL single_ready_once: got %b expected 0000", req_ready); end
    nfd = 0; fd_at = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (frame_done) begin nfd++; if (fd_at < 0) fd_at = c; end
    end
    tests++; if (nfd !== 1) begin fails++; $display("FAIL single_done_count: got %0d expected 1", nfd); end
    tests++; if (fd_at !== 12) begin fails++; $display("FAIL single_done_cycle: got %0d expected 12", fd_at); end
  endtask

  task automatic test_round_robin();
    int gids[5];
    int exp_g[5];
    int ng, fall, bad_sp, bad_busy, bad_data;
    logic prevb;
    exp_g = '{0, 1, 2, 3, 0};
    do_reset();
    req_data = 32'h44332211; cfg_gap = 4'd2; busy_len = 10; model_en = 1'b1;
    cfg_par_en = 1'b0; cfg_par_type = 1'b0; req_valid = 4'b1111;
    ng = 0; fall = -100; bad_sp = 0; bad_busy = 0; bad_data = 0; prevb = 1'b0;
    for (int c = 0; c < 200 && ng < 5; c++) begin
      @(negedge clk);
      if (prevb && !tx_busy) fall = c;
      prevb = tx_busy;
      if (req_ready != '0 && ng > 0 && (c - fall) < 3) bad_sp++;
      if (tx_data_valid) begin
        if (tx_busy) bad_busy++;
        if (int'(tx_p_data) != 17 * (int'(grant_id) + 1)) bad_data++;
        gids[ng] = int'(grant_id);
        ng++;
      end
    end
    @(posedge clk); #1 req_valid = '0;
    tests++; if (ng !== 5) begin fails++; $display("FAIL rr_grant_count: got %0d expected 5", ng); end
    for (int k = 0; k < ng; k++) begin
      tests++; if (gids[k] !== exp_g[k]) begin fails++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, gids[k], exp_g[k]); end
    end
    tests++; if (bad_sp !== 0) begin fails++; $display("FAIL rr_spacing: got %0d early grants expected 0", bad_sp); end
    tests++; if (bad_busy !== 0) begin fails++; $display("FAIL rr_load_while_busy: got %0d expected 0", bad_busy); end
    tests++; if (bad_data !== 0) begin fails++; $display("FAIL rr_data: got %0d wrong bytes expected 0", bad_data); end
  endtask

  task automatic test_timeout();
    int dv_at, to_at, ndv, nto, nfd;
    do_reset();
    model_en = 1'b0; forced_busy = 1'b0; cfg_gap = '0;
    req_data = 32'h0000_00C3; req_valid = 4'b0001;
    dv_at = -1; to_at = -1; ndv = 0; nto = 0; nfd = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (tx_data_valid) begin ndv++; if (dv_at < 0) dv_at = c; end
      if (timeout_err) begin nto++; if (to_at < 0) to_at = c; end
      if (frame_done) nfd++;
      if (req_ready != '0) begin @(posedge clk); #1 req_valid = '0; end
    end
    tests++; if (ndv !== 1) begin fails++; $display("FAIL to_valid_count: got %0d expected 1", ndv); end
    tests++; if (nto !== 1) begin fails++; $display("FAIL to_err_count: got %0d expected 1", nto); end
    tests++; if (to_at - dv_at !== BT) begin fails++; $display("FAIL to_latency: got %0d expected %0d", to_at - dv_at, BT); end
    tests++; if (nfd !== 0) begin fails++; $display("FAIL to_no_done: got %0d expected 0", nfd); end
    @(posedge clk); #1 req_valid = 4'b0010;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL to_back_idle: got %b expected 0010", req_ready); end
  endtask

  task automatic test_busy_at_request();
    int nr;
    do_reset();
    model_en = 1'b0; forced_busy = 1'b1; req_data = 32'h7E00_0000; req_valid = 4'b1000;
    nr = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready != '0) nr++;
    end
    tests++; if (nr !== 0) begin fails++; $display("FAIL busy_no_grant: got %0d grants expected 0", nr); end
    @(posedge clk); #1 forced_busy = 1'b0;
    @(negedge clk);
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL busy_grant_after: got %b expected 1000", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    tests++; if ({tx_data_valid, grant_id, tx_p_data} !== {1'b1, 2'd3, 8'h7E}) begin
      fails++; $display("FAIL busy_load: got %b/%0d/%h expected 1/3/7e", tx_data_valid, grant_id, tx_p_data); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    do_reset();
    model_en = 1'b1; busy_len = 11; cfg_gap = '0; cfg_par_en = 1'b1; cfg_par_type = 1'b1;
    req_data = 32'h0066_0000; req_valid = 4'b0100;
    @(negedge clk);
    @(posedge clk); #1 req_valid = '0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_busy) begin ok = 1'b1; break; end
    end
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL mid_busy_seen: got %b expected 1", ok); end
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0; model_en = 1'b0; req_valid = 4'b1111; req_data = 32'h44332211;
    @(negedge clk);
    tests++; if ({req_ready, tx_data_valid, frame_done} !== 6'b0) begin
      fails++; $display("FAIL mid_in_reset: got %b expected 000000", {req_ready, tx_data_valid, frame_done}); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    tests++; if ({tx_p_data, grant_id, tx_par_en, tx_par_type, tx_data_valid, frame_done} !== 14'b0) begin
      fails++; $display("FAIL mid_cleared: got %h/%0d/%b%b/%b/%b expected all 0", tx_p_data, grant_id, tx_par_en, tx_par_type, tx_data_valid, frame_done); end
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_ptr_reset: got %b expected 0001", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    tests++; if ({tx_data_valid, grant_id, tx_p_data} !== {1'b1, 2'd0, 8'h11}) begin
      fails++; $display("FAIL mid_first_grant: got %b/%0d/%h expected 1/0/11", tx_data_valid, grant_id, tx_p_data); end
  endtask

  task automatic test_stability();
    int fcyc, gcyc, dcyc, nbad;
    logic [NR-1:0] gr;
    logic [DW-1:0] d_data;
    logic d_pt, d_pe;
    bit ok;
    do_reset();
    model_en = 1'b1; busy_len = 11; cfg_gap = '0; cfg_par_en = 1'b1; cfg_par_type = 1'b1;
    req_data = 32'h0000_5A00; req_valid = 4'b0010;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL stab_grant: got %b expected 0010", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_busy) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    @(posedge clk); #1;
    req_data = 32'hFFFF_FFFF; cfg_par_type = 1'b0; cfg_par_en = 1'b0; req_valid = 4'b0001;
    fcyc = -1; gcyc = -1; dcyc = -1; nbad = 0; gr = '0; d_data = '0; d_pt = 1'b1; d_pe = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (frame_done && fcyc < 0) fcyc = c;
      if (req_ready != '0 && gcyc < 0) begin gcyc = c; gr = req_ready; end
      if (tx_data_valid) begin dcyc = c; d_data = tx_p_data; d_pt = tx_par_type; d_pe = tx_par_en; break; end
      if (tx_p_data !== 8'h5A || tx_par_type !== 1'b1 || tx_par_en !== 1'b1) nbad++;
      if (gcyc == c) begin @(posedge clk); #1 req_valid = '0; end
    end
    tests++; if (ok !== 1'b1 || fcyc < 0) begin fails++; $display("FAIL stab_frame_done: got busy=%b done_at=%0d expected frame done", ok, fcyc); end
    tests++; if (nbad !== 0) begin fails++; $display("FAIL stab_hold: got %0d changed cycles expected 0", nbad); end
    tests++; if (gr !== 4'b0001 || gcyc - fcyc !== 2) begin fails++; $display("FAIL stab_regrant: got %b at +%0d expected 0001 at +2", gr, gcyc - fcyc); end
    tests++; if (dcyc - fcyc !== 3) begin fails++; $display("FAIL stab_gap0_spacing: got %0d expected 3", dcyc - fcyc); end
    tests++; if ({d_data, d_pt, d_pe} !== {8'hFF, 1'b0, 1'b0}) begin
      fails++; $display("FAIL stab_new_values: got %h/%b/%b expected ff/0/0", d_data, d_pt, d_pe); end
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_data = '0; cfg_par_en = 1'b0; cfg_par_type = 1'b0;
    cfg_gap = '0; model_en = 1'b0; forced_busy = 1'b0; busy_len = 10;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_busy_at_request();
    test_reset_midframe();
    test_stability();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
